// File: rtl/alu_res_pkg.sv
// Shared types for the ALU result/flag capture path: flag layout and the queued
// result entry carried from the capture stage into the writeback FIFO.
package alu_res_pkg;

  localparam int ALU_FLAGS_W = 6;
  localparam int FLG_C = 5;
  localparam int FLG_O = 4;
  localparam int FLG_A = 3;
  localparam int FLG_S = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_P = 0;

  localparam int RES_DATA_W = 65;
  localparam int REG_ADDR_W = 5;

  typedef logic [ALU_FLAGS_W-1:0] except_flags;

  typedef struct packed {
    logic                  thread;
    logic [REG_ADDR_W-1:0] reg_tag;
    logic [RES_DATA_W-1:0] data;
    except_flags           flags;
    logic                  perr;
    logic                  valid;
  } res_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Ring buffer of result entries with a per-entry valid bit. A thread flush clears
// valid bits in place; the head steps over cleared slots one per cycle.
module alu_res_fifo
  import alu_res_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  res_entry_t                    push_ent,
  input  logic                          pop,
  input  logic                          flush,
  input  logic                          flush_thread,
  output logic                          head_vld,
  output logic [REG_ADDR_W-1:0]         head_reg,
  output logic [RES_DATA_W-1:0]         head_data,
  output except_flags                   head_flags,
  output logic                          head_perr,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int AW = $clog2(DEPTH);

  res_entry_t      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     cnt;
  logic            empty;
  logic            full;
  logic            skip;
  logic            advance;
  logic            do_push;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign head_vld = !empty && mem[rd_ptr].valid;
  assign skip     = !empty && !mem[rd_ptr].valid;
  assign advance  = (pop && head_vld) || skip;
  // A full ring still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || advance);

  assign head_reg   = mem[rd_ptr].reg_tag;
  assign head_data  = mem[rd_ptr].data;
  assign head_flags = mem[rd_ptr].flags;
  assign head_perr  = mem[rd_ptr].perr;
  assign count      = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (advance) rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, advance})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (flush && (mem[i].thread == flush_thread)) mem[i].valid <= 1'b0;
    end
    if (do_push) mem[wr_ptr] <= push_ent;
  end

  overflow_a : assert property (@(posedge clk) disable iff (!rst) !(push && full && !advance));

endmodule

// File: rtl/alu_res_capture.sv
// Receiving end of the ALU result/flag interface: captures the parity-protected
// result word, merges the flag word one cycle later and queues it for writeback.
module alu_res_capture
  import alu_res_pkg::*;
#(
  parameter int REG_WIDTH = REG_ADDR_W,
  parameter int DEPTH     = 4,
  parameter int FLAGS_W   = ALU_FLAGS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  except,
  input  logic                  except_thread,
  input  logic                  res_en,
  input  logic                  res_thread,
  input  logic [REG_WIDTH-1:0]  res_reg,
  input  logic [65:0]           valRes,
  input  logic                  flg_en,
  input  logic [FLAGS_W-1:0]    flg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_WIDTH-1:0]  out_reg,
  output logic [64:0]           out_data,
  output logic [FLAGS_W-1:0]    out_flags,
  output logic                  out_perr,
  output logic                  stall,
  output logic                  perr_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] STALL_TH = (AW+2)'(DEPTH - 1);

  function automatic logic parity_err(input logic [65:0] w);
    return w[65] ^ (^w[64:0]);
  endfunction

  logic                  vld_p1;
  logic                  thr_p1;
  logic [REG_WIDTH-1:0]  reg_p1;
  logic [64:0]           data_p1;
  logic                  perr_p1;

  logic                  cap;
  logic                  push;
  res_entry_t            push_ent;
  logic                  head_vld;
  logic [REG_WIDTH-1:0]  head_reg;
  logic [64:0]           head_data;
  logic [FLAGS_W-1:0]    head_flags;
  logic                  head_perr;
  logic [AW:0]           count;

  // S1: result word capture; a same-thread flush blocks the capture
  assign cap = res_en && !(except && (res_thread == except_thread));

  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= cap;
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      thr_p1  <= res_thread;
      reg_p1  <= res_reg;
      data_p1 <= valRes[64:0];
      perr_p1 <= parity_err(valRes);
    end
  end

  // Merge: S1 plus this cycle's flag word is pushed at the edge closing the cycle
  assign push = vld_p1 && !(except && (thr_p1 == except_thread));

  always_comb begin
    push_ent         = '0;
    push_ent.thread  = thr_p1;
    push_ent.reg_tag = reg_p1;
    push_ent.data    = data_p1;
    push_ent.flags   = flg_en ? flg : '0;
    push_ent.perr    = perr_p1;
    push_ent.valid   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)                 perr_sticky <= 1'b0;
    else if (push && perr_p1) perr_sticky <= 1'b1;
  end

  alu_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_ent     (push_ent),
    .pop          (out_ready),
    .flush        (except),
    .flush_thread (except_thread),
    .head_vld     (head_vld),
    .head_reg     (head_reg),
    .head_data    (head_data),
    .head_flags   (head_flags),
    .head_perr    (head_perr),
    .count        (count)
  );

  // Output: head contents, forced to zero while no valid head is presented
  assign out_valid = head_vld;
  assign out_reg   = head_vld ? head_reg   : '0;
  assign out_data  = head_vld ? head_data  : '0;
  assign out_flags = head_vld ? head_flags : '0;
  assign out_perr  = head_vld ? head_perr  : 1'b0;

  // One slot is kept for S1 and one for an issue already in flight when stall rises.
  assign stall = ({1'b0, count} + (AW+2)'(vld_p1)) >= STALL_TH;

endmodule
